// File: rtl/pc_fetch_unit_pkg.sv
// Shared types and default sizing for the fetch-address generator.
package otter_pc_pkg;

  localparam int unsigned XLEN_DEF       = 32;
  localparam int unsigned ALIGN_BITS_DEF = 2;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pc_state_t;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Pipeline/memory-facing signal bundle of the fetch unit; master is the fetch unit itself.
interface pc_fetch_unit_if import otter_pc_pkg::*; #(
  parameter int unsigned XLEN = XLEN_DEF
);
  logic            pc_stall;
  logic            fetch_ready;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_target;
  logic            trap_valid;
  logic [XLEN-1:0] trap_vector;
  logic [XLEN-1:0] PC_CNT;
  logic [XLEN-1:0] pc_next_seq;
  logic            fetch_valid;
  logic            misalign_err;
  logic            wrap_pulse;

  modport master (
    input  pc_stall, fetch_ready, redirect_valid, redirect_target, trap_valid, trap_vector,
    output PC_CNT, pc_next_seq, fetch_valid, misalign_err, wrap_pulse
  );

  modport slave (
    output pc_stall, fetch_ready, redirect_valid, redirect_target, trap_valid, trap_vector,
    input  PC_CNT, pc_next_seq, fetch_valid, misalign_err, wrap_pulse
  );
endinterface

// File: rtl/pc_fetch_unit_redirect_buf.sv
// One-entry holding register for a redirect that arrived while fetch could not advance.
module pc_redirect_buf import otter_pc_pkg::*; #(
  parameter int unsigned XLEN = XLEN_DEF
) (
  input  logic            pc_clk,
  input  logic            pc_rst_n,
  input  logic            capture,
  input  logic [XLEN-1:0] capture_target,
  input  logic            clear,
  output logic            pend_valid,
  output logic [XLEN-1:0] pend_target
);

  // A newer capture simply overwrites the held target: latest redirect wins.
  always_ff @(posedge pc_clk or negedge pc_rst_n) begin
    if (!pc_rst_n) begin
      pend_valid  <= 1'b0;
      pend_target <= '0;
    end else if (clear) begin
      pend_valid  <= 1'b0;
    end else if (capture) begin
      pend_valid  <= 1'b1;
      pend_target <= capture_target;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program-counter generator: sequential fetch, branch redirects (with stall buffering),
// trap entry and a halt on misaligned redirect targets.
//
// state | meaning
// BOOT  | first cycle after reset, no fetch issued
// RUN   | normal fetch, PC advances when not stalled and memory ready
// HALT  | misaligned redirect seen, PC frozen until a trap
module pc_fetch_unit import otter_pc_pkg::*; #(
  parameter int unsigned     XLEN         = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int unsigned     ALIGN_BITS   = ALIGN_BITS_DEF
) (
  input  logic           pc_clk,
  input  logic           pc_rst_n,
  pc_fetch_unit_if.master bus
);

  localparam logic [XLEN-1:0] INC        = XLEN'(1) << ALIGN_BITS;
  localparam logic [XLEN-1:0] ALIGN_MASK = INC - XLEN'(1);

  pc_state_t       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, pc_seq, tgt;
  logic            mis_q, mis_d, wrap_q, wrap_d;
  logic            advance, tgt_sel, buf_capture, buf_clear;
  logic            pend_valid;
  logic [XLEN-1:0] pend_target;

  assign advance = (state_q == RUN) && !bus.pc_stall && bus.fetch_ready;
  assign pc_seq  = pc_q + INC;

  pc_redirect_buf #(.XLEN(XLEN)) u_redirect_buf (
    .pc_clk         (pc_clk),
    .pc_rst_n       (pc_rst_n),
    .capture        (buf_capture),
    .capture_target (bus.redirect_target),
    .clear          (buf_clear),
    .pend_valid     (pend_valid),
    .pend_target    (pend_target)
  );

  always_ff @(posedge pc_clk or negedge pc_rst_n) begin
    if (!pc_rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_VECTOR;
      mis_q   <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      mis_q   <= mis_d;
      wrap_q  <= wrap_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    mis_d       = mis_q;
    wrap_d      = 1'b0;
    buf_capture = 1'b0;
    buf_clear   = 1'b0;
    tgt_sel     = 1'b0;
    tgt         = bus.redirect_target;
    if (bus.trap_valid) begin
      pc_d      = bus.trap_vector & ~ALIGN_MASK;
      state_d   = RUN;
      mis_d     = 1'b0;
      buf_clear = 1'b1;
    end else begin
      unique case (state_q)
        BOOT: state_d = RUN;
        RUN: begin
          if (advance) begin
            // A live redirect is newer information than the buffered one, so it wins.
            if (bus.redirect_valid) begin
              tgt_sel = 1'b1;
              tgt     = bus.redirect_target;
            end else if (pend_valid) begin
              tgt_sel = 1'b1;
              tgt     = pend_target;
            end
            buf_clear = pend_valid;
            if (tgt_sel) begin
              if (|(tgt & ALIGN_MASK)) begin
                state_d = HALT;
                mis_d   = 1'b1;
              end else begin
                pc_d = tgt;
              end
            end else begin
              pc_d   = pc_seq;
              wrap_d = (pc_seq == '0);
            end
          end else if (bus.redirect_valid) begin
            buf_capture = 1'b1;
          end
        end
        HALT: state_d = HALT;
        default: state_d = BOOT;
      endcase
    end
  end

  assign bus.PC_CNT       = pc_q;
  assign bus.pc_next_seq  = pc_seq;
  assign bus.fetch_valid  = (state_q == RUN) && !bus.pc_stall;
  assign bus.misalign_err = mis_q;
  assign bus.wrap_pulse   = wrap_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed scoreboard bench for pc_fetch_unit: each step queues the expected post-edge outputs.
module tb_pc_fetch_unit;

  typedef struct {
    logic [31:0] pc;
    logic        fv;
    logic        mis;
    logic        wrap;
  } exp_t;

  logic   pc_clk = 1'b0;
  logic   pc_rst_n = 1'b0;
  exp_t   sb[$];
  int     checks = 0;
  int     failures = 0;

  pc_fetch_unit_if #(.XLEN(32)) bus ();

  pc_fetch_unit #(
    .XLEN         (32),
    .RESET_VECTOR (32'h0000_0000),
    .ALIGN_BITS   (2)
  ) dut (
    .pc_clk   (pc_clk),
    .pc_rst_n (pc_rst_n),
    .bus      (bus)
  );

  always #5 pc_clk = ~pc_clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step(input string tag,
                      input logic st, input logic rdy,
                      input logic rv, input logic [31:0] rt,
                      input logic tv, input logic [31:0] tvec,
                      input logic [31:0] epc, input logic efv,
                      input logic emis, input logic ewrap);
    exp_t e;
    logic [31:0] eseq;
    bus.pc_stall        = st;
    bus.fetch_ready     = rdy;
    bus.redirect_valid  = rv;
    bus.redirect_target = rt;
    bus.trap_valid      = tv;
    bus.trap_vector     = tvec;
    sb.push_back('{pc: epc, fv: efv, mis: emis, wrap: ewrap});
    @(posedge pc_clk);
    #1;
    e = sb.pop_front();
    eseq = e.pc + 32'd4;
    check_val({tag, ".pc"},   bus.PC_CNT,              e.pc);
    check_val({tag, ".fv"},   {31'd0, bus.fetch_valid}, {31'd0, e.fv});
    check_val({tag, ".mis"},  {31'd0, bus.misalign_err}, {31'd0, e.mis});
    check_val({tag, ".wrap"}, {31'd0, bus.wrap_pulse},  {31'd0, e.wrap});
    check_val({tag, ".seq"},  bus.pc_next_seq,          eseq);
  endtask

  initial begin
    bus.pc_stall        = 1'b0;
    bus.fetch_ready     = 1'b1;
    bus.redirect_valid  = 1'b0;
    bus.redirect_target = '0;
    bus.trap_valid      = 1'b0;
    bus.trap_vector     = '0;

    #2;
    check_val("rst.pc",   bus.PC_CNT, 32'h0);
    check_val("rst.fv",   {31'd0, bus.fetch_valid},  32'd0);
    check_val("rst.mis",  {31'd0, bus.misalign_err}, 32'd0);
    check_val("rst.wrap", {31'd0, bus.wrap_pulse},   32'd0);
    #10;
    pc_rst_n = 1'b1;
    #1;
    check_val("boot.fv", {31'd0, bus.fetch_valid}, 32'd0);

    // startup and sequential fetch
    step("boot", 0,1, 0,32'h0, 0,32'h0, 32'h0, 1,0,0);
    step("seq4", 0,1, 0,32'h0, 0,32'h0, 32'h4, 1,0,0);
    step("seq8", 0,1, 0,32'h0, 0,32'h0, 32'h8, 1,0,0);

    // stalled redirects, latest wins
    step("tr10",   0,1, 0,32'h0,   1,32'h10, 32'h10,  1,0,0);
    step("rd200",  1,1, 1,32'h200, 0,32'h0,  32'h10,  0,0,0);
    step("rd300",  1,1, 1,32'h300, 0,32'h0,  32'h10,  0,0,0);
    step("hold",   1,1, 0,32'h0,   0,32'h0,  32'h10,  0,0,0);
    step("use300", 0,1, 0,32'h0,   0,32'h0,  32'h300, 1,0,0);
    step("s304",   0,1, 0,32'h0,   0,32'h0,  32'h304, 1,0,0);

    // memory not ready buffers the redirect too
    step("nrdy",   0,0, 1,32'h700, 0,32'h0, 32'h304, 1,0,0);
    step("use700", 0,1, 0,32'h0,   0,32'h0, 32'h700, 1,0,0);
    step("s704",   0,1, 0,32'h0,   0,32'h0, 32'h704, 1,0,0);

    // live redirect beats pending one
    step("rd900",   1,1, 1,32'h900, 0,32'h0, 32'h704, 0,0,0);
    step("liveA00", 0,1, 1,32'hA00, 0,32'h0, 32'hA00, 1,0,0);
    step("sA04",    0,1, 0,32'h0,   0,32'h0, 32'hA04, 1,0,0);

    // misaligned live redirect halts, trap recovers with aligned vector
    step("tr40",    0,1, 0,32'h0,   1,32'h40,  32'h40,  1,0,0);
    step("rd102",   0,1, 1,32'h102, 0,32'h0,   32'h40,  0,1,0);
    step("haltign", 0,1, 1,32'h200, 0,32'h0,   32'h40,  0,1,0);
    step("tr1C3",   0,1, 0,32'h0,   1,32'h1C3, 32'h1C0, 1,0,0);
    step("s1C4",    0,1, 0,32'h0,   0,32'h0,   32'h1C4, 1,0,0);

    // misaligned pending redirect halts when applied
    step("rd106",  1,1, 1,32'h106, 0,32'h0,   32'h1C4, 0,0,0);
    step("use106", 0,1, 0,32'h0,   0,32'h0,   32'h1C4, 0,1,0);
    step("tr600",  0,1, 0,32'h0,   1,32'h600, 32'h600, 1,0,0);

    // modulo wrap
    step("trFFC", 0,1, 0,32'h0, 1,32'hFFFF_FFFC, 32'hFFFF_FFFC, 1,0,0);
    step("wrap",  0,1, 0,32'h0, 0,32'h0,         32'h0,         1,0,1);
    step("post",  0,1, 0,32'h0, 0,32'h0,         32'h4,         1,0,0);

    // trap beats redirect under stall, nothing buffered
    step("trap_rd", 1,1, 1,32'h400, 1,32'h800, 32'h800, 0,0,0);
    step("s804",    0,1, 0,32'h0,   0,32'h0,   32'h804, 1,0,0);

    // async reset with a pending redirect
    step("rdB00", 1,1, 1,32'hB00, 0,32'h0, 32'h804, 0,0,0);
    bus.redirect_valid = 1'b0;
    bus.pc_stall       = 1'b0;
    #2;
    pc_rst_n = 1'b0;
    #1;
    check_val("mrst.pc",  bus.PC_CNT, 32'h0);
    check_val("mrst.fv",  {31'd0, bus.fetch_valid},  32'd0);
    check_val("mrst.mis", {31'd0, bus.misalign_err}, 32'd0);
    #1;
    pc_rst_n = 1'b1;
    step("rboot", 0,1, 0,32'h0, 0,32'h0, 32'h0, 1,0,0);
    step("r4",    0,1, 0,32'h0, 0,32'h0, 32'h4, 1,0,0);
    step("r8",    0,1, 0,32'h0, 0,32'h0, 32'h8, 1,0,0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
